sdram_pro_wr_fifo_ctrl: RTL and testbench

//  Write-side buffer/controller sitting directly upstream of the SDRAM page-burst write engine.

---
 rtl/sdram_pro_wr_fifo_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_sdram_pro_wr_fifo_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pro_wr_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_pro_wr_fifo_ctrl
// Write-side buffer in front of the SDRAM page-burst write engine.
//  - Buffers user words in a first-word-fall-through FIFO (2**FIFO_AW deep).
//  - Requests a burst (wr_en) once the stored word count reaches the configured
//    burst length, then pops one word per wr_ack.
//  - Advances the SDRAM address after each completed burst, wrapping back to
//    the window base when the next burst would start past the window end.
// Optional feature (compile-time macro SDRAM_WR_FLUSH_EN):
//  adds input user_flush, which lets a partially filled FIFO be written out
//  as a short burst while the controller is idle.
// -----------------------------------------------------------------------------
module sdram_pro_wr_fifo_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 23,
    parameter int FIFO_AW = 10
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    // user write side
    input  logic                 user_wr_en,
    input  logic [DATA_W-1:0]    user_wr_data,
    output logic                 user_full,
    // configuration / status from the SDRAM core
    input  logic                 init_end,
    input  logic [9:0]           wr_burst_len_cfg,
    input  logic [ADDR_W-1:0]    wr_base_addr,
    input  logic [ADDR_W-1:0]    wr_end_addr,
    // write engine side
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [9:0]           wr_burst_len,
    output logic [DATA_W-1:0]    wr_data,
    input  logic                 wr_ack,
    input  logic                 wr_end,
    // status
    output logic [FIFO_AW:0]     fifo_level,
    output logic [1:0]           err_flags
`ifdef SDRAM_WR_FLUSH_EN
    ,
    input  logic                 user_flush
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   level_reg;
    logic [FIFO_AW:0]   level_next;
    logic               full_reg;
    logic [1:0]         err_reg;

    logic               fifo_empty;
    logic               push;
    logic               pop;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_t             state_reg;
    state_t             state_next;

    logic               normal_req;
    logic               flush_req;
    logic               req_load;
    logic               burst_done;
    logic [9:0]         req_len;

    logic [ADDR_W-1:0]  wr_addr_reg;
    logic [9:0]         wr_burst_len_reg;
    logic [ADDR_W-1:0]  base_lat_reg;
    logic [ADDR_W-1:0]  end_lat_reg;
    logic               first_req_reg;

    logic [ADDR_W:0]    addr_sum;
    logic [ADDR_W-1:0]  addr_next;

    // Pushes are gated by the registered full flag, pops by the live level;
    // both sides may fire in the same cycle.
    assign fifo_empty = (level_reg == '0);
    assign push       = user_wr_en && !full_reg;
    assign pop        = wr_ack && !fifo_empty;

    // Level bookkeeping: simultaneous push and pop leave the count unchanged.
    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // FIFO pointers, level, full flag and sticky error flags.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            err_reg    <= 2'b00;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
            full_reg  <= (level_next == FULL_LEVEL);
            // bit 1: ack seen with nothing stored, bit 0: push dropped while full
            err_reg   <= err_reg | {wr_ack && fifo_empty, user_wr_en && full_reg};
        end
    end

    // Storage write port; contents need no reset because the pointers define validity.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= user_wr_data;
        end
    end

    // Head word is presented combinationally so it is valid in the ack cycle.
    assign wr_data = mem[rd_ptr_reg];

    // -------------------------------------------------------------------------
    // Request conditions
    // -------------------------------------------------------------------------
    assign normal_req = init_end
                     && (wr_burst_len_cfg != 10'd0)
                     && (level_reg >= (FIFO_AW+1)'(wr_burst_len_cfg));

`ifdef SDRAM_WR_FLUSH_EN
    // A flush only matters when there is something stored but not a full burst.
    assign flush_req  = init_end
                     && user_flush
                     && !fifo_empty
                     && (level_reg < (FIFO_AW+1)'(wr_burst_len_cfg));
`else
    assign flush_req  = 1'b0;
`endif

    // A full burst takes precedence; otherwise a flush drains whatever is stored.
    assign req_len = normal_req ? wr_burst_len_cfg : 10'(level_reg);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic (wr_end wins over wr_ack while still requesting).
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (normal_req || flush_req) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wr_end) begin
                    state_next = ST_IDLE;
                end else if (wr_ack) begin
                    state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wr_end) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs and datapath strobes decoded from the current state.
    always_comb begin
        wr_en      = 1'b0;
        req_load   = 1'b0;
        burst_done = 1'b0;
        case (state_reg)
            ST_IDLE:  req_load   = normal_req || flush_req;
            ST_REQ:   wr_en      = 1'b1;
            ST_BURST: burst_done = wr_end;
            default: begin
                wr_en      = 1'b0;
                req_load   = 1'b0;
                burst_done = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address generation
    // -------------------------------------------------------------------------
    // One extra bit so a sum past the top of the address space still compares
    // as beyond the window end instead of wrapping silently.
    assign addr_sum  = {1'b0, wr_addr_reg} + (ADDR_W+1)'(wr_burst_len_reg);
    assign addr_next = (addr_sum > {1'b0, end_lat_reg}) ? base_lat_reg
                                                         : addr_sum[ADDR_W-1:0];

    // Burst parameters are captured on entry to REQ and held until the burst
    // closes; an aborted request (wr_end in REQ) leaves the address alone.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_addr_reg      <= '0;
            wr_burst_len_reg <= '0;
            base_lat_reg     <= '0;
            end_lat_reg      <= '0;
            first_req_reg    <= 1'b1;
        end else begin
            if (req_load) begin
                wr_burst_len_reg <= req_len;
                base_lat_reg     <= wr_base_addr;
                end_lat_reg      <= wr_end_addr;
                if (first_req_reg) begin
                    wr_addr_reg   <= wr_base_addr;
                    first_req_reg <= 1'b0;
                end
            end else if (burst_done) begin
                wr_addr_reg <= addr_next;
            end
        end
    end

    assign wr_addr      = wr_addr_reg;
    assign wr_burst_len = wr_burst_len_reg;
    assign fifo_level   = level_reg;
    assign user_full    = full_reg;
    assign err_flags    = err_reg;

endmodule

// File: tb/tb_sdram_pro_wr_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdram_pro_wr_fifo_ctrl
// Self-checking bench. The bench plays both the user and the write engine.
// Reference model: a queue of stored words, sticky flag bits, and the address
// rule (next = addr + len, back to base when past the window end).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sdram_pro_wr_fifo_ctrl;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        user_wr_en;
    logic [15:0] user_wr_data;
    logic        user_full;
    logic        init_end;
    logic [9:0]  wr_burst_len_cfg;
    logic [22:0] wr_base_addr;
    logic [22:0] wr_end_addr;
    logic        wr_en;
    logic [22:0] wr_addr;
    logic [9:0]  wr_burst_len;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        wr_end;
    logic [10:0] fifo_level;
    logic [1:0]  err_flags;
    logic        user_flush;

    sdram_pro_wr_fifo_ctrl dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .user_wr_en       (user_wr_en),
        .user_wr_data     (user_wr_data),
        .user_full        (user_full),
        .init_end         (init_end),
        .wr_burst_len_cfg (wr_burst_len_cfg),
        .wr_base_addr     (wr_base_addr),
        .wr_end_addr      (wr_end_addr),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_burst_len     (wr_burst_len),
        .wr_data          (wr_data),
        .wr_ack           (wr_ack),
        .wr_end           (wr_end),
        .fifo_level       (fifo_level),
`ifdef SDRAM_WR_FLUSH_EN
        .user_flush       (user_flush),
`endif
        .err_flags        (err_flags)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks;
    int failures;

    // reference model state
    logic [15:0] mq[$];
    logic [1:0]  m_err;
    bit          m_first;
    logic [22:0] m_addr;
    logic [22:0] req_base;
    logic [22:0] req_end;
    logic [9:0]  req_len;

    int lat;
    int need;
    int nacks;
    int mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus; the model applies the FIFO rules to it.
    task automatic cyc(input logic we, input logic [15:0] wd, input logic ack, input logic wend);
        bit was_full;
        bit was_empty;
        user_wr_en   = we;
        user_wr_data = wd;
        wr_ack       = ack;
        wr_end       = wend;
        was_full  = (mq.size() == 1024);
        was_empty = (mq.size() == 0);
        if (ack && !was_empty) chk("wr_data", 32'(wr_data), 32'(mq[0]));
        if (ack && was_empty)  m_err[1] = 1'b1;
        if (we && was_full)    m_err[0] = 1'b1;
        if (ack && !was_empty) void'(mq.pop_front());
        if (we && !was_full)   mq.push_back(wd);
        @(negedge sys_clk);
        user_wr_en = 1'b0;
        wr_ack     = 1'b0;
        wr_end     = 1'b0;
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("err_flags", 32'(err_flags), 32'(m_err));
        chk("user_full", 32'(user_full), 32'(mq.size() == 1024));
    endtask

    task automatic wait_req(output int cycles);
        cycles = 0;
        while (wr_en !== 1'b1 && cycles < 40) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b0);
            cycles++;
        end
        chk("req_seen", 32'(wr_en), 32'd1);
    endtask

    // Record a request in the model and compare its address and length.
    task automatic note_req(input logic [9:0] exp_len);
        if (m_first) begin
            m_addr  = wr_base_addr;
            m_first = 1'b0;
        end
        req_base = wr_base_addr;
        req_end  = wr_end_addr;
        req_len  = exp_len;
        chk("req_addr", 32'(wr_addr), 32'(m_addr));
        chk("req_len", 32'(wr_burst_len), 32'(req_len));
    endtask

    // Engine side of a burst: nacks acks with random stalls, then wr_end.
    task automatic run_burst(input int n, input bit allow_push);
        logic [23:0] nxt;
        logic        pw;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                pw = allow_push && ($urandom_range(0, 2) == 0);
                cyc(pw, 16'($urandom), 1'b0, 1'b0);
                chk("wr_en_hold", 32'(wr_en), 32'(i == 0));
            end
            pw = allow_push && ($urandom_range(0, 2) == 0);
            cyc(pw, 16'($urandom), 1'b1, 1'b0);
            chk("wr_en_drop", 32'(wr_en), 32'd0);
        end
        chk("addr_stable", 32'(wr_addr), 32'(m_addr));
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        nxt = {1'b0, m_addr} + 24'(req_len);
        if (nxt > {1'b0, req_end}) m_addr = req_base;
        else                       m_addr = nxt[22:0];
        chk("wr_en_gap", 32'(wr_en), 32'd0);
        chk("addr_next", 32'(wr_addr), 32'(m_addr));
        $display("burst len=%0d acks=%0d next_addr=0x%0h level=%0d", req_len, n, wr_addr, fifo_level);
    endtask

    task automatic do_reset();
        sys_rst_n    = 1'b0;
        user_wr_en   = 1'b0;
        user_wr_data = 16'h0;
        wr_ack       = 1'b0;
        wr_end       = 1'b0;
        user_flush   = 1'b0;
        mq.delete();
        m_err   = 2'b00;
        m_first = 1'b1;
        m_addr  = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_len"}, 32'(wr_burst_len), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_err"}, 32'(err_flags), 32'd0);
        chk({tag, "_full"}, 32'(user_full), 32'd0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        init_end         = 1'b0;
        wr_burst_len_cfg = 10'd8;
        wr_base_addr     = 23'h0;
        wr_end_addr      = 23'h7FFFFF;
        do_reset();

        // reset state
        chk_zero("rst");

        // first burst: words 1..8, no request until init_end
        for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
        repeat (5) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b0);
            chk("no_req_before_init", 32'(wr_en), 32'd0);
        end
        init_end = 1'b1;
        wait_req(lat);
        note_req(10'd8);
        chk("burst1_addr", 32'(wr_addr), 32'h0);
        run_burst(8, 1'b0);
        chk("burst1_empty", 32'(fifo_level), 32'd0);

        // second burst at address 8; window shrunk so the third wraps to 0
        wr_end_addr = 23'h0F;
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        wait_req(lat);
        // push in cycle N -> level in N+1 -> wr_en in N+2, i.e. one cycle after
        // the push cycle's sampling point here
        chk("req_latency", 32'(lat), 32'd1);
        note_req(10'd8);
        chk("burst2_addr", 32'(wr_addr), 32'h8);
        run_burst(8, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        wait_req(lat);
        note_req(10'd8);
        chk("burst3_wrap", 32'(wr_addr), 32'h0);
        run_burst(8, 1'b0);

        // randomized bursts: varying cfg/window, aborts, short bursts, pushes mid-burst
        for (int it = 0; it < 12; it++) begin
            need = int'(wr_burst_len_cfg) - mq.size() + $urandom_range(0, 3);
            for (int k = 0; k < need; k++) begin
                if ($urandom_range(0, 3) == 0) cyc(1'b0, 16'h0, 1'b0, 1'b0);
                cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
            end
            wait_req(lat);
            note_req(wr_burst_len_cfg);
            mode = $urandom_range(0, 5);
            if (mode == 0) begin
                cyc(1'b0, 16'h0, 1'b0, 1'b1);
                chk("abort_gap", 32'(wr_en), 32'd0);
                chk("abort_addr", 32'(wr_addr), 32'(m_addr));
                wait_req(lat);
                note_req(wr_burst_len_cfg);
            end
            nacks = (mode == 1 && req_len > 1) ? int'(req_len) - 1 : int'(req_len);
            run_burst(nacks, 1'b1);
            wr_burst_len_cfg = (it == 11) ? 10'd0 : 10'($urandom_range(1, 12));
            wr_base_addr     = 23'($urandom_range(0, 64));
            wr_end_addr      = wr_base_addr + 23'($urandom_range(8, 40));
        end

        // cfg=0 never requests; drain, then push+ack together at level 5
        while (mq.size() > 0) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 16'($urandom), 1'b1, 1'b0);
            chk("pushpop_level5", 32'(fifo_level), 32'd5);
        end
        chk("cfg0_no_req", 32'(wr_en), 32'd0);

        // ack on empty: underflow flag, read pointer holds
        while (mq.size() > 0) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("underflow_flag", 32'(err_flags[1]), 32'd1);
        cyc(1'b1, 16'hA5A5, 1'b0, 1'b0);
        chk("rdptr_hold", 32'(wr_data), 32'hA5A5);

        // reset in the middle of a burst (asynchronous, checked before any edge)
        do_reset();
        wr_burst_len_cfg = 10'd4;
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        wait_req(lat);
        note_req(10'd4);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        wr_burst_len_cfg = 10'd0;
        do_reset();

        // fill to 1024, then overflow
        for (int i = 0; i < 1024; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        chk("full_level", 32'(fifo_level), 32'd1024);
        chk("full_flag", 32'(user_full), 32'd1);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("ovf_flags", 32'(err_flags), 32'h1);
        chk("ovf_level", 32'(fifo_level), 32'd1024);
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("after_full_level", 32'(fifo_level), 32'd1020);

`ifdef SDRAM_WR_FLUSH_EN
        // flush: ignored when empty, otherwise a short burst of what is stored
        do_reset();
        wr_burst_len_cfg = 10'd16;
        user_flush = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        user_flush = 1'b0;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("flush_empty_ignored", 32'(wr_en), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("partial_waits", 32'(wr_en), 32'd0);
        user_flush = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        user_flush = 1'b0;
        chk("flush_req", 32'(wr_en), 32'd1);
        note_req(10'd3);
        run_burst(3, 1'b0);
        chk("flush_drained", 32'(fifo_level), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
